// File: rtl/axi_burst_rd_master.sv
// AXI4 INCR burst read initiator: splits a (start address, beat count) command into
// single-outstanding bursts and streams R beats out. Optional R skid buffer: AXI_RD_MASTER_SKID_EN.
module axi_burst_rd_master #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  nbeats,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic              m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);

  localparam int BYTES = DATA_W / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_NEXT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [8:0]        bcnt_q, bcnt_d;
  logic [7:0]        arlen_q, arlen_d;
  logic              arvalid_q, arvalid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] start_addr, nxt_addr;
  logic [8:0]        first_beats, nxt_beats;
  logic              r_hs, last_beat, buf_empty;
  logic              unused_ok;

  // Beats in the next burst: limited by what is left, MAX_BURST and the 4 KB page end.
  function automatic logic [8:0] burst_beats(input logic [ADDR_W-1:0] a,
                                             input logic [LEN_W-1:0]  rem);
    logic [12:0] to4k;
    logic [12:0] n;
    to4k = (13'd4096 - {1'b0, a[11:0]}) >> SIZE;
    n    = (rem > LEN_W'(MAX_BURST)) ? 13'(MAX_BURST) : 13'(rem);
    if (to4k < n) n = to4k;
    return 9'(n);
  endfunction

  assign unused_ok   = ^{addr[SIZE-1:0], m_axi_rid};
  assign start_addr  = {addr[ADDR_W-1:SIZE], {SIZE{1'b0}}};
  assign first_beats = burst_beats(start_addr, nbeats);
  assign nxt_addr    = addr_q + (ADDR_W'({1'b0, arlen_q} + 9'd1) << SIZE);
  assign nxt_beats   = burst_beats(nxt_addr, rem_q);
  assign r_hs        = m_axi_rvalid && m_axi_rready;
  assign last_beat   = (bcnt_q == 9'd1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    bcnt_d    = bcnt_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (nbeats != '0) begin
            state_d   = S_ADDR;
            busy_d    = 1'b1;
            addr_d    = start_addr;
            arvalid_d = 1'b1;
            arlen_d   = 8'(first_beats - 9'd1);
            rem_d     = nbeats - LEN_W'(first_beats);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          bcnt_d    = {1'b0, arlen_q} + 9'd1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          bcnt_d = bcnt_q - 9'd1;
          // The local beat count is authoritative; rlast is only cross-checked.
          if ((m_axi_rlast != last_beat) || (m_axi_rresp != 2'b00)) err_d = 1'b1;
          if (last_beat) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (rem_q == '0) begin
          if (buf_empty) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          addr_d    = nxt_addr;
          arlen_d   = 8'(nxt_beats - 9'd1);
          rem_d     = rem_q - LEN_W'(nxt_beats);
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      bcnt_q    <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      bcnt_q    <= bcnt_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef AXI_RD_MASTER_SKID_EN
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rready_q, rready_d;
  logic              pop;

  assign pop = (cnt_q != 2'd0) && dout_ready;

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    unique case ({r_hs, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = m_axi_rdata;
        else               buf1_d = m_axi_rdata;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = m_axi_rdata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = m_axi_rdata;
        end
      end
      default: ;
    endcase
    // Registered ready: only offer a slot that is guaranteed free next cycle.
    rready_d = (state_d == S_DATA) && (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_q   <= '0;
      buf1_q   <= '0;
      cnt_q    <= 2'd0;
      rready_q <= 1'b0;
    end else begin
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      cnt_q    <= cnt_d;
      rready_q <= rready_d;
    end
  end

  assign dout         = buf0_q;
  assign dout_valid   = (cnt_q != 2'd0);
  assign m_axi_rready = rready_q;
  assign buf_empty    = (cnt_q == 2'd0);
`else
  assign dout         = m_axi_rdata;
  assign dout_valid   = m_axi_rvalid && (state_q == S_DATA);
  assign m_axi_rready = dout_ready && (state_q == S_DATA);
  assign buf_empty    = 1'b1;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign m_axi_arid    = 1'b0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_arvalid = arvalid_q;

endmodule

// File: tb/tb_axi_burst_rd_master.sv
// Self-checking bench for axi_burst_rd_master: AXI read responder, burst/beat reference model.
`timescale 1ns/1ps
module tb_axi_burst_rd_master;
  localparam int ADDR_W = 30, DATA_W = 256, MAX_BURST = 16, LEN_W = 20, BYTES = DATA_W / 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [LEN_W-1:0]  nbeats = '0;
  logic busy, done, err, arid, arlock, arvalid, rready, dout_valid;
  logic arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, dout_ready = 1'b0;
  logic [ADDR_W-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst;
  logic [3:0] arcache, arqos;
  logic [1:0] rresp = 2'b00;
  logic [DATA_W-1:0] rdata = '0, dout;

  always #5 clk = ~clk;

  axi_burst_rd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .nbeats(nbeats),
    .busy(busy), .done(done), .err(err),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(1'b0), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready));

  typedef struct {logic [ADDR_W-1:0] a; int len;} ar_t;
  ar_t ar_obs[$], ar_exp[$], r_pend[$];
  logic [DATA_W-1:0] beat_obs[$], beat_exp[$];

  int checks = 0, failures = 0;
  int ar_delay = 0, rdy_mode = 0, rgap = 0, err_beat = -1;
  int gbeat = 0, r_idx = 0, ar_wait = 0;
  int stab_viol = 0, order_viol = 0, attr_viol = 0, arv_cycles = 0, done_cycles = 0;
  bit s_ar_hs = 0, s_r_hs = 0, prev_wait = 0;
  logic [ADDR_W-1:0] prev_addr = '0, s_ar_a = '0;
  logic [7:0] prev_len = '0;
  int s_ar_len = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory contents as a pure function of the beat address.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = {2'b00, a} ^ (32'h1000_0001 * (i + 1));
    return w;
  endfunction

  // Reference: expected AR list and beat stream from the splitting rules.
  task automatic build_exp(input logic [ADDR_W-1:0] a0, input int n);
    longint a, span;
    int rem, to4k, len;
    span = longint'(1) << ADDR_W;
    a = (longint'(a0) / BYTES) * BYTES;
    rem = n;
    ar_exp.delete();
    beat_exp.delete();
    for (int i = 0; i < n; i++) beat_exp.push_back(mem_word(ADDR_W'((a + i * BYTES) % span)));
    while (rem > 0) begin
      to4k = (4096 - int'(a % 4096)) / BYTES;
      len = rem;
      if (len > MAX_BURST) len = MAX_BURST;
      if (len > to4k) len = to4k;
      ar_exp.push_back('{ADDR_W'(a), len - 1});
      a = (a + len * BYTES) % span;
      rem -= len;
    end
  endtask

  // Monitor: sample between active edges.
  always @(negedge clk) begin
    s_ar_hs = rst_n && arvalid && arready;
    s_r_hs  = rst_n && rvalid && rready;
    if (rst_n) begin
      if (arvalid) arv_cycles++;
      if (done) done_cycles++;
      if (prev_wait && (!arvalid || araddr !== prev_addr || arlen !== prev_len)) stab_viol++;
      prev_wait = arvalid && !arready;
      prev_addr = araddr;
      prev_len  = arlen;
      if (s_ar_hs) begin
        if (r_pend.size() != 0) order_viol++;
        if (arsize !== 3'd5 || arburst !== 2'b01 || arcache !== 4'b0011 || arid !== 1'b0 ||
            arlock !== 1'b0 || arprot !== 3'd0 || arqos !== 4'd0) attr_viol++;
        s_ar_a = araddr;
        s_ar_len = int'(arlen);
        ar_obs.push_back('{araddr, int'(arlen)});
      end
      if (dout_valid && dout_ready) beat_obs.push_back(dout);
    end else begin
      prev_wait = 1'b0;
    end
  end

  // AXI slave responder and stream sink, driven just after the active edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
      r_pend.delete(); r_idx = 0; ar_wait = 0;
    end else begin
      if (s_ar_hs) begin
        r_pend.push_back('{s_ar_a, s_ar_len});
        arready = 1'b0;
        ar_wait = 0;
      end else if (arvalid) begin
        arready = (ar_wait >= ar_delay);
        ar_wait++;
      end else begin
        arready = 1'b0;
      end
      if (s_r_hs) begin
        gbeat++;
        if (r_pend.size() != 0) begin
          if (r_idx == r_pend[0].len) begin
            void'(r_pend.pop_front());
            r_idx = 0;
          end else begin
            r_idx++;
          end
        end
        rvalid = 1'b0;
      end
      if (!rvalid && r_pend.size() != 0 && !(rgap != 0 && $urandom_range(0, 2) == 0)) begin
        rvalid = 1'b1;
        rdata  = mem_word(r_pend[0].a + ADDR_W'(r_idx * BYTES));
        rlast  = (r_idx == r_pend[0].len);
        rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
      end
    end
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ~dout_ready;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic run_cmd(input string tag, input logic [ADDR_W-1:0] a, input int n,
                         input bit exp_err, input bit poke);
    bit seen;
    int nb;
    build_exp(a, n);
    ar_obs.delete(); beat_obs.delete();
    gbeat = 0; arv_cycles = 0; done_cycles = 0; stab_viol = 0; order_viol = 0; attr_viol = 0;
    @(posedge clk); #2;
    start = 1'b1; addr = a; nbeats = LEN_W'(n);
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    check({tag, "/busy"}, busy, 1'b1);
    seen = 0;
    for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 6) begin start = 1'b1; addr = a + 30'h4000; nbeats = 20'd3; end
      if (poke && cyc == 7) start = 1'b0;
      if (done) begin
        seen = 1;
        check({tag, "/busy_at_done"}, busy, 1'b0);
      end
    end
    check({tag, "/done_seen"}, seen, 1'b1);
    @(negedge clk);
    check({tag, "/done_pulse"}, done, 1'b0);
    check({tag, "/done_count"}, done_cycles, 1);
    check({tag, "/ar_count"}, ar_obs.size(), ar_exp.size());
    for (int i = 0; i < ar_obs.size() && i < ar_exp.size(); i++) begin
      check({tag, "/araddr"}, ar_obs[i].a, ar_exp[i].a);
      check({tag, "/arlen"}, ar_obs[i].len, ar_exp[i].len);
    end
    check({tag, "/beat_count"}, beat_obs.size(), beat_exp.size());
    nb = (beat_obs.size() < beat_exp.size()) ? beat_obs.size() : beat_exp.size();
    for (int i = 0; i < nb; i++) check({tag, "/beat"}, beat_obs[i], beat_exp[i]);
    check({tag, "/err"}, err, exp_err);
    check({tag, "/ar_stable"}, stab_viol, 0);
    check({tag, "/ar_after_last_r"}, order_viol, 0);
    check({tag, "/ar_attrs"}, attr_viol, 0);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst/busy", busy, 1'b0);
    check("rst/done", done, 1'b0);
    check("rst/err", err, 1'b0);
    check("rst/arvalid", arvalid, 1'b0);
    check("rst/rready", rready, 1'b0);
    check("rst/dout_valid", dout_valid, 1'b0);
    check("rst/araddr", araddr, '0);
    check("rst/arlen", arlen, 8'd0);
    check("rst/dout", dout, '0);
    @(posedge clk); #2 rst_n = 1'b1;

    ar_delay = 0; rdy_mode = 0; rgap = 0; err_beat = -1;
    run_cmd("single16", 30'h0, 16, 0, 0);
    run_cmd("split40", 30'h0, 40, 0, 0);
    run_cmd("cross4k", 30'hFC0, 8, 0, 0);
    run_cmd("unaligned", 30'h1234, 5, 0, 0);
    run_cmd("wrap", 30'h3FFF_FFC0, 4, 0, 0);

    ar_delay = 3; rdy_mode = 1; rgap = 1;
    run_cmd("backpress20", 30'h100, 20, 0, 0);
    run_cmd("ignore_start", 30'h2000, 40, 0, 1);

    // Zero-length command.
    ar_delay = 0; rdy_mode = 0; rgap = 0; arv_cycles = 0;
    @(posedge clk); #2;
    start = 1'b1; addr = 30'h800; nbeats = '0;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    check("zero/done", done, 1'b1);
    check("zero/busy", busy, 1'b0);
    @(negedge clk);
    check("zero/done_pulse", done, 1'b0);
    repeat (3) @(negedge clk);
    check("zero/no_ar", arv_cycles, 0);

    err_beat = 3;
    run_cmd("rresp_err", 30'h400, 12, 1, 0);
    err_beat = -1;
    run_cmd("err_cleared", 30'h600, 6, 0, 0);

    for (int k = 0; k < 6; k++) begin
      ar_delay = $urandom_range(0, 4);
      rdy_mode = $urandom_range(0, 2);
      rgap = $urandom_range(0, 1);
      run_cmd("random", ADDR_W'($urandom), $urandom_range(1, 70), 0, 0);
    end

    // Reset in the middle of a command.
    ar_delay = 0; rdy_mode = 0; rgap = 0;
    @(posedge clk); #2;
    start = 1'b1; addr = 30'h0; nbeats = 20'd40;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst/busy", busy, 1'b0);
    check("midrst/arvalid", arvalid, 1'b0);
    check("midrst/rready", rready, 1'b0);
    check("midrst/dout_valid", dout_valid, 1'b0);
    check("midrst/done", done, 1'b0);
    check("midrst/araddr", araddr, '0);
    check("midrst/arlen", arlen, 8'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_cmd("after_rst", 30'h3000, 18, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
